mmio_arbiter: RTL

Two-master arbiter sharing the single CPU MMIO port between the CPU core and a second bus master (debug/loader or DMA). It accepts at most one transaction per cycle and registers the winner onto the downstream MMIO bus. It tracks outstanding reads and routes read data back to the issuing master after a fixed downstream latency. It sits between `cpu_top`'s MMIO signals and the peripheral decoder.

---
 rtl/mmio_pkg.sv | 19 +
 rtl/mmio_rd_tracker.sv | 41 ++++
 rtl/mmio_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared MMIO arbiter types: default bus widths, owner tag and transaction record.
package mmio_pkg;

  localparam int MMIO_ADDR_W = 30;
  localparam int MMIO_DATA_W = 32;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  typedef struct packed {
    logic [MMIO_ADDR_W-1:0]   addr;
    logic [MMIO_DATA_W-1:0]   data;
    logic [MMIO_DATA_W/8-1:0] mask;
    logic                     wren;
  } mmio_txn_t;

endpackage

// File: rtl/mmio_rd_tracker.sv
// RD_LAT-deep {valid, owner} shift register; entry reaches the tail RD_LAT cycles after push.
// Shifts unconditionally every cycle, so it never applies backpressure.
module mmio_rd_tracker #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic owner,
  output logic tail_vld,
  output logic tail_owner
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] own_q, own_d;

  always_comb begin
    vld_d    = vld_q;
    own_d    = own_q;
    vld_d[0] = push;
    own_d[0] = owner;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
    end
  end

  assign tail_vld   = vld_q[RD_LAT-1];
  assign tail_owner = own_q[RD_LAT-1];

endmodule

// File: rtl/mmio_arbiter.sv
// Two-master MMIO arbiter: combinational grant, registered downstream strobe at T+1, read data back at T+1+RD_LAT.
// Never stalls a single requester; MMIO_ARB_RR_EN selects round-robin, otherwise m0 has fixed priority.
module mmio_arbiter
  import mmio_pkg::*;
#(
  parameter int ADDR_W = MMIO_ADDR_W,
  parameter int DATA_W = MMIO_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_mask,
  input  logic                  m0_wren,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_mask,
  input  logic                  m1_wren,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [ADDR_W-1:0]     o_mmio_addr,
  output logic [DATA_W-1:0]     o_mmio_data,
  output logic [DATA_W/8-1:0]   o_mmio_mask,
  output logic                  o_mmio_wren,
  output logic                  o_mmio_rden,
  input  logic [DATA_W-1:0]     i_mmio_data
);

  localparam int MASK_W = DATA_W / 8;

  // Local copy of the transaction record so it follows the module parameters.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
    logic              wren;
  } txn_t;

  txn_t m0_txn, m1_txn;
  txn_t txn_q, txn_d;
  logic rden_q, rden_d;
  logic owner_q, owner_d;
  logic trk_vld, trk_owner;

  assign m0_txn = '{addr: m0_addr, data: m0_wdata, mask: m0_mask, wren: m0_wren};
  assign m1_txn = '{addr: m1_addr, data: m1_wdata, mask: m1_mask, wren: m1_wren};

`ifdef MMIO_ARB_RR_EN
  logic pri_q, pri_d;

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
      if (m0_req && (!m1_req || pri_q == OWN_M0)) begin
        m0_gnt = 1'b1;
      end else if (m1_req) begin
        m1_gnt = 1'b1;
      end
    end
  end

  // Priority moves to whichever master lost (or did not ask) this cycle.
  always_comb begin
    pri_d = pri_q;
    if (m0_gnt) begin
      pri_d = OWN_M1;
    end else if (m1_gnt) begin
      pri_d = OWN_M0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pri_q <= OWN_M0;
    end else begin
      pri_q <= pri_d;
    end
  end
`else
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
      if (m0_req) begin
        m0_gnt = 1'b1;
      end else if (m1_req) begin
        m1_gnt = 1'b1;
      end
    end
  end
`endif

  // Address/data/mask hold when idle; only the strobes drop back to zero.
  always_comb begin
    txn_d      = txn_q;
    txn_d.wren = 1'b0;
    rden_d     = 1'b0;
    owner_d    = owner_q;
    if (m0_gnt) begin
      txn_d   = m0_txn;
      rden_d  = ~m0_wren;
      owner_d = OWN_M0;
    end else if (m1_gnt) begin
      txn_d   = m1_txn;
      rden_d  = ~m1_wren;
      owner_d = OWN_M1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_q   <= '0;
      rden_q  <= 1'b0;
      owner_q <= OWN_M0;
    end else begin
      txn_q   <= txn_d;
      rden_q  <= rden_d;
      owner_q <= owner_d;
    end
  end

  assign o_mmio_addr = txn_q.addr;
  assign o_mmio_data = txn_q.data;
  assign o_mmio_mask = txn_q.mask;
  assign o_mmio_wren = txn_q.wren;
  assign o_mmio_rden = rden_q;

  // Fed from the registered strobe so the tail lines up with i_mmio_data.
  mmio_rd_tracker #(
    .RD_LAT (RD_LAT)
  ) u_rd_tracker (
    .clk        (clk),
    .rst        (rst),
    .push       (rden_q),
    .owner      (owner_q),
    .tail_vld   (trk_vld),
    .tail_owner (trk_owner)
  );

  assign m0_rvalid = trk_vld && (trk_owner == OWN_M0);
  assign m1_rvalid = trk_vld && (trk_owner == OWN_M1);
  assign m0_rdata  = m0_rvalid ? i_mmio_data : '0;
  assign m1_rdata  = m1_rvalid ? i_mmio_data : '0;

endmodule
